// File: rtl/y86_pkg.sv
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared Y86-64 fetch constants, FSM state type and length info.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'd0;
    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_CMOVXX = 4'd2;
    localparam logic [3:0] I_IRMOVQ = 4'd3;
    localparam logic [3:0] I_RMMOVQ = 4'd4;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSHQ  = 4'd10;
    localparam logic [3:0] I_POPQ   = 4'd11;

    localparam logic [3:0] IFUN_MAX_CMOV = 4'd6;
    localparam logic [3:0] IFUN_MAX_OPQ  = 4'd3;
    localparam logic [3:0] IFUN_MAX_JXX  = 4'd6;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        VALID   = 2'd1,
        WAIT_PC = 2'd2,
        HALT    = 2'd3
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/y86_fetch_if.sv
// ============================================================================
//  Module      : y86_fetch_if
//  Description : Byte-wide instruction-memory read bus (one outstanding request).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface y86_fetch_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [7:0]  imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

`default_nettype wire

// File: rtl/y86_ins_len.sv
// ============================================================================
//  Module      : y86_ins_len
//  Description : Maps {icode, ifun} to instruction length and field usage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module y86_ins_len
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    input  logic [3:0] i_ifun,
    output logic [3:0] o_len,
    output logic       o_has_reg,
    output logic       o_has_const,
    output logic       o_invalid
);

    logic w_bad;

    always_comb begin
        o_len       = 4'd1;
        o_has_reg   = 1'b0;
        o_has_const = 1'b0;
        w_bad       = 1'b0;
        case (i_icode)
            I_HALT, I_NOP, I_RET: begin
                w_bad = (i_ifun != 4'd0);
            end
            I_CMOVXX: begin
                o_len     = 4'd2;
                o_has_reg = 1'b1;
                w_bad     = (i_ifun > IFUN_MAX_CMOV);
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                o_len       = 4'd10;
                o_has_reg   = 1'b1;
                o_has_const = 1'b1;
                w_bad       = (i_ifun != 4'd0);
            end
            I_OPQ: begin
                o_len     = 4'd2;
                o_has_reg = 1'b1;
                w_bad     = (i_ifun > IFUN_MAX_OPQ);
            end
            I_JXX: begin
                o_len       = 4'd9;
                o_has_const = 1'b1;
                w_bad       = (i_ifun > IFUN_MAX_JXX);
            end
            I_CALL: begin
                o_len       = 4'd9;
                o_has_const = 1'b1;
                w_bad       = (i_ifun != 4'd0);
            end
            I_PUSHQ, I_POPQ: begin
                o_len     = 4'd2;
                o_has_reg = 1'b1;
                w_bad     = (i_ifun != 4'd0);
            end
            default: begin
                w_bad = 1'b1;
            end
        endcase
        // An illegal encoding is consumed as a single byte with no operands.
        if (w_bad) begin
            o_len       = 4'd1;
            o_has_reg   = 1'b0;
            o_has_const = 1'b0;
        end
        o_invalid = w_bad;
    end

endmodule

`default_nettype wire

// File: rtl/y86_fetch.sv
// ============================================================================
//  Module      : y86_fetch
//  Description : Byte-serial Y86-64 fetch stage; optional address bound check
//                enabled by macro FETCH_BOUND_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module y86_fetch
    import y86_pkg::*;
#(
    parameter int          IMEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC   = 64'd0
) (
    input  logic               clk,
    input  logic               rst,
    y86_fetch_if.master        imem,
    input  logic               pc_load,
    input  logic [63:0]        new_PC_address,
    output logic               ins_valid,
    input  logic               ins_ready,
    output logic [3:0]         Ins_Code,
    output logic [3:0]         Ins_fun,
    output logic [3:0]         rA,
    output logic [3:0]         rB,
    output logic [63:0]        Val_C,
    output logic [63:0]        Val_P,
    output logic [63:0]        PC_adress,
    output logic               instruction_invalid_check,
    output logic               mem_invalid_check,
    output logic               halted
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [3:0]   k_q, k_d;
    logic [3:0]   icode_q, icode_d;
    logic [3:0]   ifun_q, ifun_d;
    logic [3:0]   ra_q, ra_d;
    logic [3:0]   rb_q, rb_d;
    logic [63:0]  valc_q, valc_d;
    logic [63:0]  valp_q, valp_d;
    logic         inv_q, inv_d;
    logic         mem_inv_q, mem_inv_d;

    logic [63:0]  w_addr;
    logic         w_oob;
    logic [3:0]   w_icode;
    logic [3:0]   w_ifun;
    logic [3:0]   w_len;
    logic         w_has_reg;
    logic         w_has_const;
    logic         w_invalid;
    logic [2:0]   w_cidx;

    generate
        if (IMEM_BYTES < 1) begin : g_bad_imem_bytes
            $error("IMEM_BYTES must be positive");
        end
    endgenerate

    assign w_addr = pc_q + {60'd0, k_q};

`ifdef FETCH_BOUND_CHECK_EN
    assign w_oob             = (w_addr >= 64'(IMEM_BYTES));
    assign mem_invalid_check = mem_inv_q;
`else
    assign w_oob             = 1'b0;
    assign mem_invalid_check = 1'b0;
`endif

    // Length info comes from the live byte while byte 0 is on the bus.
    assign w_icode = (k_q == 4'd0) ? imem.imem_data[7:4] : icode_q;
    assign w_ifun  = (k_q == 4'd0) ? imem.imem_data[3:0] : ifun_q;

    y86_ins_len u_ins_len (
        .i_icode     (w_icode),
        .i_ifun      (w_ifun),
        .o_len       (w_len),
        .o_has_reg   (w_has_reg),
        .o_has_const (w_has_const),
        .o_invalid   (w_invalid)
    );

    assign w_cidx = 3'(k_q - (w_has_reg ? 4'd2 : 4'd1));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        k_d       = k_q;
        icode_d   = icode_q;
        ifun_d    = ifun_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        valc_d    = valc_q;
        valp_d    = valp_q;
        inv_d     = inv_q;
        mem_inv_d = mem_inv_q;
        case (state_q)
            FETCH: begin
                if (w_oob) begin
                    mem_inv_d = 1'b1;
                    valp_d    = w_addr;
                    state_d   = VALID;
                end else if (imem.imem_ack) begin
                    if (k_q == 4'd0) begin
                        icode_d = imem.imem_data[7:4];
                        ifun_d  = imem.imem_data[3:0];
                        ra_d    = RNONE;
                        rb_d    = RNONE;
                        valc_d  = 64'd0;
                        inv_d   = w_invalid;
                    end else if (w_has_reg && (k_q == 4'd1)) begin
                        ra_d = imem.imem_data[7:4];
                        rb_d = imem.imem_data[3:0];
                    end else if (w_has_const) begin
                        valc_d[{w_cidx, 3'b000} +: 8] = imem.imem_data;
                    end
                    if (k_q == w_len - 4'd1) begin
                        k_d     = 4'd0;
                        valp_d  = pc_q + {60'd0, w_len};
                        state_d = VALID;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
            end
            VALID: begin
                if (ins_ready) begin
                    state_d = ((icode_q == I_HALT) || inv_q || mem_inv_q) ? HALT : WAIT_PC;
                end
            end
            WAIT_PC: begin
                if (pc_load) begin
                    pc_d    = new_PC_address;
                    k_d     = 4'd0;
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            k_q       <= 4'd0;
            icode_q   <= 4'd0;
            ifun_q    <= 4'd0;
            ra_q      <= 4'd0;
            rb_q      <= 4'd0;
            valc_q    <= 64'd0;
            valp_q    <= 64'd0;
            inv_q     <= 1'b0;
            mem_inv_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            k_q       <= k_d;
            icode_q   <= icode_d;
            ifun_q    <= ifun_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            valc_q    <= valc_d;
            valp_q    <= valp_d;
            inv_q     <= inv_d;
            mem_inv_q <= mem_inv_d;
        end
    end

    // The reset state is FETCH, so the request is held off while rst is high.
    assign imem.imem_req  = (state_q == FETCH) && !rst && !w_oob;
    assign imem.imem_addr = w_addr;

    assign ins_valid                 = (state_q == VALID);
    assign halted                    = (state_q == HALT);
    assign Ins_Code                  = icode_q;
    assign Ins_fun                   = ifun_q;
    assign rA                        = ra_q;
    assign rB                        = rb_q;
    assign Val_C                     = valc_q;
    assign Val_P                     = valp_q;
    assign PC_adress                 = pc_q;
    assign instruction_invalid_check = inv_q;

endmodule

`default_nettype wire

// File: tb/tb_y86_fetch.sv
// ============================================================================
//  Module      : tb_y86_fetch
//  Description : Self-checking bench for y86_fetch (directed + random steps).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_y86_fetch;

`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND   = 1'b1;
    localparam int TB_IMEM = 16;
`else
    localparam bit BOUND   = 1'b0;
    localparam int TB_IMEM = 1024;
`endif
    localparam logic [63:0] TB_RESET_PC = 64'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_load = 1'b0;
    logic [63:0] new_PC_address = 64'd0;
    logic        ins_ready = 1'b0;
    logic        ins_valid;
    logic [3:0]  Ins_Code, Ins_fun, rA, rB;
    logic [63:0] Val_C, Val_P, PC_adress;
    logic        instruction_invalid_check, mem_invalid_check, halted;

    y86_fetch_if imem ();

    y86_fetch #(.IMEM_BYTES(TB_IMEM), .RESET_PC(TB_RESET_PC)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .imem                      (imem),
        .pc_load                   (pc_load),
        .new_PC_address            (new_PC_address),
        .ins_valid                 (ins_valid),
        .ins_ready                 (ins_ready),
        .Ins_Code                  (Ins_Code),
        .Ins_fun                   (Ins_fun),
        .rA                        (rA),
        .rB                        (rB),
        .Val_C                     (Val_C),
        .Val_P                     (Val_P),
        .PC_adress                 (PC_adress),
        .instruction_invalid_check (instruction_invalid_check),
        .mem_invalid_check         (mem_invalid_check),
        .halted                    (halted)
    );

    always #5 clk = ~clk;

    // Memory model: ack after ack_delay waiting cycles, byte read from mem.
    logic [7:0]  mem [0:1023];
    int          ack_delay = 0;
    int          wcnt = 0;
    logic [63:0] addr_log [$];

    assign imem.imem_ack  = imem.imem_req && (wcnt >= ack_delay);
    assign imem.imem_data = mem[imem.imem_addr[9:0]];

    always @(posedge clk) begin
        if (imem.imem_req && imem.imem_ack) begin
            addr_log.push_back(imem.imem_addr);
            wcnt <= 0;
        end else if (imem.imem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: decode tables straight from the ISA definition.
    int LEN_TAB  [12] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2};
    int FMAX_TAB [12] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0};

    typedef struct {
        logic [3:0]  ic, fn, ra, rb;
        logic [63:0] vc, vp;
        logic        inv, merr, halt;
        int          fetched;
    } exp_t;

    function automatic logic [7:0] rd(input logic [63:0] a);
        logic [9:0] i;
        i = a[9:0];
        return mem[i];
    endfunction

    function automatic bit avail(input logic [63:0] a);
        return !BOUND || (a < 64'(TB_IMEM));
    endfunction

    function automatic exp_t model(input logic [63:0] pc);
        exp_t       e;
        logic [7:0] b;
        int         len, stop;
        b      = rd(pc);
        e.ic   = b[7:4];
        e.fn   = b[3:0];
        e.ra   = 4'hF;
        e.rb   = 4'hF;
        e.vc   = 64'd0;
        e.inv  = 1'b0;
        e.merr = 1'b0;
        if (int'(e.ic) > 11) e.inv = 1'b1;
        else if (int'(e.fn) > FMAX_TAB[int'(e.ic)]) e.inv = 1'b1;
        len  = e.inv ? 1 : LEN_TAB[int'(e.ic)];
        stop = len;
        for (int k = 1; k < len; k++)
            if (stop == len && !avail(pc + 64'(k))) begin
                stop   = k;
                e.merr = 1'b1;
            end
        if ((len == 2 || len == 10) && stop > 1) begin
            b    = rd(pc + 64'd1);
            e.ra = b[7:4];
            e.rb = b[3:0];
        end
        if (len >= 9)
            for (int i = 0; i < 8; i++)
                if (len - 8 + i < stop) begin
                    b    = rd(pc + 64'(len - 8 + i));
                    e.vc = e.vc | (64'(b) << (8 * i));
                end
        e.vp      = pc + 64'(stop);
        e.fetched = stop;
        e.halt    = (e.ic == 4'd0) || e.inv || e.merr;
        return e;
    endfunction

    task automatic chk_out(input string ph, input exp_t e, input logic [63:0] pc);
        chk({ph, ".valid"}, ins_valid, 1);
        chk({ph, ".icode"}, Ins_Code, e.ic);
        chk({ph, ".ifun"}, Ins_fun, e.fn);
        chk({ph, ".rA"}, rA, e.ra);
        chk({ph, ".rB"}, rB, e.rb);
        chk({ph, ".valC"}, Val_C, e.vc);
        chk({ph, ".valP"}, Val_P, e.vp);
        chk({ph, ".pc"}, PC_adress, pc);
        chk({ph, ".inv"}, instruction_invalid_check, e.inv);
        chk({ph, ".memerr"}, mem_invalid_check, e.merr);
    endtask

    // Starts at a negedge with the DUT in FETCH at pc; ends after the handshake.
    task automatic run_ins(input logic [63:0] pc, input int rdy_wait, input bit jam,
                           output bit hexp);
        exp_t e;
        int   base, cyc;
        bit   ok;
        e    = model(pc);
        base = addr_log.size();
        cyc  = 0;
        while (!ins_valid && cyc < 500) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk("valid_seen", ins_valid, 1);
        chk("latency", 64'(cyc), 64'(e.fetched * (ack_delay + 1) + (e.merr ? 1 : 0)));
        chk_out("first", e, pc);
        ok = (addr_log.size() == base + e.fetched);
        if (ok)
            for (int i = 0; i < e.fetched; i++)
                if (addr_log[base + i] !== pc + 64'(i)) ok = 1'b0;
        chk("addr_seq", ok, 1);
        for (int h = 0; h < rdy_wait; h++) begin
            pc_load        = jam;
            new_PC_address = {$urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            chk_out("hold", e, pc);
        end
        pc_load   = 1'b0;
        ins_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ins_ready = 1'b0;
        chk("post.valid", ins_valid, 0);
        chk("post.halted", halted, e.halt);
        chk("post.req", imem.imem_req, 0);
        hexp = e.halt;
    endtask

    task automatic load_pc(input logic [63:0] pc);
        pc_load        = 1'b1;
        new_PC_address = pc;
        @(posedge clk);
        @(negedge clk);
        pc_load = 1'b0;
        chk("load.req", imem.imem_req, 1);
        chk("load.addr", imem.imem_addr, pc);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        pc_load   = 1'b0;
        ins_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Bytes listed first-to-last, left-aligned in seq.
    task automatic put(input logic [63:0] a, input logic [79:0] seq, input int n);
        logic [63:0] ai;
        for (int i = 0; i < n; i++) begin
            ai           = a + 64'(i);
            mem[ai[9:0]] = seq[79 - 8 * i -: 8];
        end
    endtask

    // Reset asserted mid-fetch, between clock edges, must act at once.
    task automatic mid_reset(input logic [63:0] pc, input int wait_cyc);
        load_pc(pc);
        repeat (wait_cyc) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid.pc_before", PC_adress, pc);
        #2 rst = 1'b1;
        #1;
        chk("mid.async_pc", PC_adress, TB_RESET_PC);
        chk("mid.req", imem.imem_req, 0);
        chk("mid.icode", Ins_Code, 0);
        chk("mid.valid", ins_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          h;
        logic [63:0] pc;
        logic [3:0]  ic, fn;
        bit          saw16;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.req", imem.imem_req, 0);
        chk("rst.valid", ins_valid, 0);
        chk("rst.icode", Ins_Code, 0);
        chk("rst.ifun", Ins_fun, 0);
        chk("rst.rA", rA, 0);
        chk("rst.rB", rB, 0);
        chk("rst.valC", Val_C, 0);
        chk("rst.valP", Val_P, 0);
        chk("rst.pc", PC_adress, TB_RESET_PC);
        chk("rst.inv", instruction_invalid_check, 0);
        chk("rst.memerr", mem_invalid_check, 0);
        chk("rst.halted", halted, 0);

`ifdef FETCH_BOUND_CHECK_EN
        ack_delay = 0;
        put(64'd0, 80'h1000_0000_0000_0000_0000, 1);
        put(64'd15, 80'h3000_0000_0000_0000_0000, 1);
        rst = 1'b0;
        run_ins(64'd0, 0, 0, h);
        load_pc(64'd15);
        run_ins(64'd15, 1, 0, h);
        chk("bound.memerr_seen", mem_invalid_check, 1);
        saw16 = 1'b0;
        foreach (addr_log[i]) if (addr_log[i] == 64'd16) saw16 = 1'b1;
        chk("bound.no_addr16", saw16, 0);
        do_reset();
        run_ins(64'd0, 0, 0, h);
        ack_delay = 3;
        mid_reset(64'd15, 2);
        run_ins(64'd0, 0, 0, h);
`else
        // irmovq $8, %rbx at address 0, ack tied high
        ack_delay = 0;
        put(64'd0, 80'h30F3_0800_0000_0000_0000, 10);
        rst = 1'b0;
        run_ins(64'd0, 0, 0, h);

        // addq %rdx, %rbx at 0x10, slow memory, consumer stalls with pc_load jammed
        put(64'h10, 80'h6023_0000_0000_0000_0000, 2);
        ack_delay = 2;
        load_pc(64'h10);
        run_ins(64'h10, 3, 1, h);

        // jmp 0x40 at 0, then an illegal opcode at the jump target
        put(64'd0, 80'h7040_0000_0000_0000_0000, 9);
        put(64'h40, 80'hC000_0000_0000_0000_0000, 1);
        ack_delay = 0;
        do_reset();
        run_ins(64'd0, 1, 0, h);
        load_pc(64'h40);
        run_ins(64'h40, 0, 0, h);

        // OPq with an out-of-range function code
        put(64'd0, 80'h6500_0000_0000_0000_0000, 1);
        do_reset();
        run_ins(64'd0, 0, 0, h);

        // halt, then a pc_load that must be ignored
        put(64'd0, 80'h0000_0000_0000_0000_0000, 1);
        do_reset();
        run_ins(64'd0, 2, 1, h);
        pc_load        = 1'b1;
        new_PC_address = 64'h40;
        @(posedge clk);
        @(negedge clk);
        pc_load = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("halt.stays", halted, 1);
        chk("halt.no_req", imem.imem_req, 0);
        chk("halt.pc", PC_adress, 64'd0);

        // randomized instruction stream
        h = 1'b1;
        for (int t = 0; t < 40; t++) begin
            pc = h ? TB_RESET_PC : 64'($urandom_range(0, 1000));
            for (int i = 0; i < 10; i++) put(pc + 64'(i), {8'($urandom), 72'd0}, 1);
            ic = ($urandom_range(0, 99) < 85) ? 4'($urandom_range(1, 11)) : 4'($urandom);
            if (int'(ic) <= 11 && $urandom_range(0, 9) < 8)
                fn = 4'($urandom_range(0, FMAX_TAB[int'(ic)]));
            else
                fn = 4'($urandom);
            put(pc, {ic, fn, 72'd0}, 1);
            ack_delay = $urandom_range(0, 2);
            if (h) do_reset();
            else load_pc(pc);
            run_ins(pc, $urandom_range(0, 3), 1'($urandom_range(0, 1)), h);
        end

        // asynchronous reset in the middle of a fetch discards partial data
        ack_delay = 0;
        put(64'd0, 80'h30F3_0800_0000_0000_0000, 10);
        do_reset();
        run_ins(64'd0, 0, 0, h);
        put(64'h100, 80'h4012_1122_3344_5566_7788, 10);
        put(64'd0, 80'hA04F_0000_0000_0000_0000, 2);
        ack_delay = 3;
        mid_reset(64'h100, 5);
        run_ins(64'd0, 1, 0, h);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/y86_fetch.md
Y86_FETCH -- requirements
Module: y86_fetch

Interface
REQ-001 SHALL have parameter IMEM_BYTES, default 1024, instruction-memory size in bytes.
REQ-002 SHALL have parameter RESET_PC, default 64'd0, PC value loaded on reset.
REQ-003 SHALL have port clk input 1, the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst input 1, asynchronous active-high reset.
REQ-005 SHALL have port pc_load input 1, one-cycle strobe carrying the next PC from the PC-update stage.
REQ-006 SHALL have port new_PC_address input 64, next PC, sampled when pc_load=1.
REQ-007 SHALL have port imem_req output 1, byte read request.
REQ-008 SHALL have port imem_addr output 64, byte address of the request.
REQ-009 SHALL have port imem_ack input 1, read completed this cycle.
REQ-010 SHALL have port imem_data input 8, read byte, valid when imem_ack=1.
REQ-011 SHALL have port ins_valid output 1, decoded instruction available.
REQ-012 SHALL have port ins_ready input 1, consumer accepts the instruction.
REQ-013 SHALL have ports Ins_Code output 4, Ins_fun output 4, rA output 4, rB output 4, Val_C output 64, Val_P output 64, PC_adress output 64 (fetched PC).
REQ-014 SHALL have ports instruction_invalid_check output 1, mem_invalid_check output 1, halted output 1.

Function
REQ-015 SHALL implement the FSM states FETCH, VALID, WAIT_PC, HALT.
REQ-016 In FETCH, SHALL hold imem_req=1 with imem_addr=PC+k, where k is the byte index, until imem_ack; at most one outstanding request.
REQ-017 Byte 0 SHALL load Ins_Code=data[7:4] and Ins_fun=data[3:0]; the register byte SHALL load rA=data[7:4] and rB=data[3:0]; the constant bytes SHALL load Val_C little-endian.
REQ-018 Lengths SHALL be: halt, nop, ret 1; cmovXX, OPq, pushq, popq 2; jXX, call 9 (Val_C at bytes 1-8); irmovq, rmmovq, mrmovq 10 (Val_C at bytes 2-9).
REQ-019 Valid ifun SHALL be 0-6 for codes 2 and 7, 0-3 for code 6, and 0 otherwise; icode>11 or an illegal ifun SHALL set instruction_invalid_check=1 with length 1.
REQ-020 Fields that the instruction does not use SHALL read 4'hF (rA, rB) or 0 (Val_C).
REQ-021 The cycle after the ack of the last byte, the FSM SHALL enter VALID with ins_valid=1 and Val_P=PC+length.
REQ-022 In VALID, all outputs SHALL remain stable until ins_ready=1; on that handshake the FSM SHALL go to HALT if Ins_Code=0 or any error flag is set, and to WAIT_PC otherwise.
REQ-023 In WAIT_PC, pc_load SHALL load PC from new_PC_address and enter FETCH next cycle.
REQ-024 pc_load SHALL be ignored in FETCH, VALID and HALT.
REQ-025 HALT SHALL assert halted=1 and imem_req=0, and SHALL be left only by reset.
REQ-026 Zero-wait latency SHALL be length+1 cycles from entering FETCH to ins_valid.

Reset
REQ-027 rst SHALL force, asynchronously: PC=RESET_PC, state FETCH (first request issued in the first cycle after release), ins_valid=0, imem_req=0 during reset, all field outputs 0, all flags 0.
REQ-028 rst mid-fetch or mid-handshake SHALL discard partial data; a late imem_ack for the discarded request is the memory's responsibility.

Configuration
REQ-029 SHALL use macro FETCH_BOUND_CHECK_EN.
REQ-030 When FETCH_BOUND_CHECK_EN is defined, a byte address >= IMEM_BYTES SHALL issue no request; instead mem_invalid_check=1 and the FSM enters VALID next cycle with the bytes fetched so far and Val_P=PC+k.
REQ-031 When FETCH_BOUND_CHECK_EN is undefined, mem_invalid_check SHALL be tied 0 and addresses SHALL wrap modulo 2^64.

Structure
REQ-032 Package y86_pkg SHALL hold the icode localparams (I_HALT..I_POPQ = 0..11), the ifun limits, the FSM state enum, and the RNONE=4'hF constant.
REQ-033 The combinational sub-module y86_ins_len SHALL map {icode, ifun} to {length, has_reg, has_const, invalid}.

Verification
REQ-034 With ack tied 1 and memory holding 30 F3 08 00 00 00 00 00 00 00 at 0, the bench SHALL see Ins_Code=3, rA=F, rB=3, Val_C=8, Val_P=10, and ins_valid in cycle 11.
REQ-035 With 60 23 at PC 0x10, 2-cycle ack delay, and ins_ready low for 3 cycles, the bench SHALL see outputs stable, OPq ifun 0, rA=2, rB=3, Val_P=0x12.
REQ-036 With 70 40 00 00 00 00 00 00 00 then pc_load with new_PC_address=0x40, the bench SHALL see Val_C=0x40 and Val_P=9, followed by the next imem_addr=0x40.
REQ-037 With byte C0 or 65, the bench SHALL see instruction_invalid_check=1 and Val_P=PC+1, then halted=1 after the handshake.
REQ-038 With byte 00, the bench SHALL see Ins_Code=0; after the handshake halted=1, and a later pc_load SHALL be ignored.
REQ-039 With FETCH_BOUND_CHECK_EN defined, IMEM_BYTES=16, and 30 at byte 15, the bench SHALL see mem_invalid_check=1 with no request to address 16; asserting rst mid-fetch SHALL return PC to RESET_PC.
